gpio_hex_display: RTL and testbench



---
 rtl/gpio_hex_display_if.sv | 11 +
 rtl/gpio_hex_display.sv | 109 ++++++++++
 tb/tb_gpio_hex_display.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_hex_display_if.sv
// Display-side bundle for gpio_hex_display: the GPIO word going in, the
// anode/segment drive and frame marker coming out.
interface gpio_hex_display_if;
  logic [31:0] value;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_start;

  modport master (output value, input AN, SEG, frame_start);
  modport slave  (input value, output AN, SEG, frame_start);
endinterface

// File: rtl/gpio_hex_display.sv
// Scans a 32-bit GPIO word as hex onto a multiplexed seven-segment display; optional GPIO_HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Latency: snapshot on the first post-reset edge and at every frame wrap, AN/SEG registered one edge later.
// Backpressure: none; value is sampled only at snapshot edges, outputs free-run.
module gpio_hex_display #(
  parameter int CLK_DIV    = 50000,
  parameter int DIGITS     = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                CLK,
  input  logic                RST,
  gpio_hex_display_if.slave   disp
);

  localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DIGITS - 1);
  // The inactive level is all ones for common-anode and all zeros otherwise.
  localparam logic [7:0]     INV      = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
  localparam logic [31:0]    DMASK    = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);
`endif

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic          load_pending;
  logic [7:0]    an_q;
  logic [7:0]    seg_q;
  logic          fs_q;

  logic          tick;
  logic          wrap;
  logic          load;
  logic [3:0]    nib;
  logic [7:0]    an_hi;
  logic [7:0]    seg_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick   = (cnt == CNT_LAST);
    wrap   = (idx == IDX_LAST);
    load   = load_pending | (tick & wrap);
    nib    = snap[{idx, 2'b00} +: 4];
    an_hi  = 8'd1 << idx;
    seg_hi = {1'b0, hex7(nib)};
`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
    // Digit 0 always shows so a zero word still reads "0".
    if ((idx != 3'd0) && (((snap & DMASK) >> {idx, 2'b00}) == 32'd0)) begin
      an_hi  = 8'h00;
      seg_hi = 8'h00;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt          <= '0;
      idx          <= 3'd0;
      snap         <= 32'd0;
      load_pending <= 1'b1;
      an_q         <= INV;
      seg_q        <= INV;
      fs_q         <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= wrap ? 3'd0 : idx + 3'd1;
      end
      if (load) begin
        snap <= disp.value;
      end
      load_pending <= 1'b0;
      fs_q         <= load;
      // Stay dark until the first snapshot has landed, so no stale digit flashes.
      if (load_pending) begin
        an_q  <= INV;
        seg_q <= INV;
      end else begin
        an_q  <= an_hi ^ INV;
        seg_q <= seg_hi ^ INV;
      end
    end
  end

  assign disp.AN          = an_q;
  assign disp.SEG         = seg_q;
  assign disp.frame_start = fs_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Bench for gpio_hex_display: three parameter sets share one clock, checked
// against an arithmetic scan model plus directed reset and delay sequences.
module tb_gpio_hex_display;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [31:0] va = 32'd0, vb = 32'd0, vc = 32'd0;

  gpio_hex_display_if ifa ();
  gpio_hex_display_if ifb ();
  gpio_hex_display_if ifc ();

  assign ifa.value = va;
  assign ifb.value = vb;
  assign ifc.value = vc;

  gpio_hex_display #(.CLK_DIV(4), .DIGITS(8), .ACTIVE_LOW(1)) dut_a (.CLK(CLK), .RST(rst_a), .disp(ifa));
  gpio_hex_display #(.CLK_DIV(1), .DIGITS(1), .ACTIVE_LOW(1)) dut_b (.CLK(CLK), .RST(rst_b), .disp(ifb));
  gpio_hex_display #(.CLK_DIV(3), .DIGITS(5), .ACTIVE_LOW(0)) dut_c (.CLK(CLK), .RST(rst_c), .disp(ifc));

`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int checks = 0;
  int errors = 0;
  logic [31:0] hist [0:1023];

  typedef struct {
    logic [31:0] v;
    logic [7:0]  seg;
  } vec_t;

  task automatic check(input string name, input int e, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %02h, expected %02h", name, e, act, exp);
    end
  endtask

  task automatic set_rst(input int dut, input logic r);
    case (dut)
      0: rst_a = r;
      1: rst_b = r;
      default: rst_c = r;
    endcase
  endtask

  task automatic set_val(input int dut, input logic [31:0] v);
    case (dut)
      0: va = v;
      1: vb = v;
      default: vc = v;
    endcase
  endtask

  function automatic logic [31:0] cur_val(input int dut);
    case (dut)
      0: return va;
      1: return vb;
      default: return vc;
    endcase
  endfunction

  task automatic get_out(input int dut, output logic [7:0] an, output logic [7:0] seg, output logic fs);
    case (dut)
      0: begin an = ifa.AN; seg = ifa.SEG; fs = ifa.frame_start; end
      1: begin an = ifb.AN; seg = ifb.SEG; fs = ifb.frame_start; end
      default: begin an = ifc.AN; seg = ifc.SEG; fs = ifc.frame_start; end
    endcase
  endtask

  // A digit above 0 is dark when every nibble from it up to the top digit is zero.
  function automatic bit is_blank(input logic [31:0] s, input int ndig, input int idx);
    bit b;
    b = (idx != 0);
    for (int k = idx; k < ndig; k++) begin
      if (s[4*k +: 4] != 4'h0) b = 1'b0;
    end
    return b & BLANK_EN;
  endfunction

  // Edge e counts rising edges after RST is released. Snapshots land on edge 1
  // and every D*N edges; the digit after edge e is the one selected by the
  // slot (e-1)/D, shown from the snapshot current at edge e-1.
  task automatic run_model(input int dut, input int D, input int N, input int AL, input int ncyc,
                           input logic [31:0] init, input bit rnd, input int chg_e, input logic [31:0] chg_v);
    logic [7:0]  an, seg, ean, eseg, inv;
    logic        fs, efs;
    int          p, idx, L;
    logic [31:0] s;
    inv = (AL != 0) ? 8'hFF : 8'h00;
    @(negedge CLK);
    set_rst(dut, 1'b1);
    set_val(dut, init);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    set_rst(dut, 1'b0);
    for (int e = 1; e <= ncyc; e++) begin
      if (e == chg_e) set_val(dut, chg_v);
      else if (rnd && $urandom_range(0, 3) == 0) set_val(dut, $urandom >> $urandom_range(0, 31));
      hist[e] = cur_val(dut);
      @(posedge CLK);
      @(negedge CLK);
      efs = (e == 1) || (e % (D * N) == 0);
      if (e == 1) begin
        ean  = inv;
        eseg = inv;
      end else begin
        p   = e - 1;
        idx = (p / D) % N;
        L   = (p / (D * N)) * (D * N);
        if (L == 0) L = 1;
        s = hist[L];
        if (is_blank(s, N, idx)) begin
          ean  = inv;
          eseg = inv;
        end else begin
          ean  = (8'd1 << idx) ^ inv;
          eseg = HEX[s[4*idx +: 4]] ^ inv;
        end
      end
      get_out(dut, an, seg, fs);
      check("scan_AN", e, an, ean);
      check("scan_SEG", e, seg, eseg);
      check("scan_frame_start", e, {7'd0, fs}, {7'd0, efs});
    end
  endtask

  initial begin
    vec_t tbl [6];
    logic [7:0] prev;

    tbl[0] = '{32'h0000_0000, 8'hC0};
    tbl[1] = '{32'h0000_0009, 8'h90};
    tbl[2] = '{32'hFFFF_FFFA, 8'h88};
    tbl[3] = '{32'h1234_567B, 8'h83};
    tbl[4] = '{32'h0000_000E, 8'h86};
    tbl[5] = '{32'h8000_0004, 8'h99};

    // Reset state and first visible digit.
    @(negedge CLK);
    rst_a = 1'b1;
    va    = 32'h0000_ABCD;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check("reset_AN", 0, ifa.AN, 8'hFF);
    check("reset_SEG", 0, ifa.SEG, 8'hFF);
    check("reset_frame_start", 0, {7'd0, ifa.frame_start}, 8'h00);
    rst_a = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("first_edge_AN", 1, ifa.AN, 8'hFF);
    check("first_edge_frame_start", 1, {7'd0, ifa.frame_start}, 8'h01);
    @(posedge CLK);
    @(negedge CLK);
    check("first_digit_AN", 2, ifa.AN, 8'hFE);
    check("first_digit_SEG", 2, ifa.SEG, 8'hA1);

    // Scan order, period and snapshot stability across a mid-frame value change.
    run_model(0, 4, 8, 1, 70, 32'h0000_ABCD, 1'b0, 13, 32'h1234_5678);

    // Reset while digit 5 is being shown.
    run_model(0, 4, 8, 1, 22, 32'h00C0_FFEE, 1'b0, 0, 32'd0);
    @(negedge CLK);
    rst_a = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("midreset_AN", 0, ifa.AN, 8'hFF);
    check("midreset_SEG", 0, ifa.SEG, 8'hFF);
    check("midreset_frame_start", 0, {7'd0, ifa.frame_start}, 8'h00);
    rst_a = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check("midreset_restart_AN", 2, ifa.AN, 8'hFE);
    check("midreset_restart_SEG", 2, ifa.SEG, 8'h86);

    // Single digit, divide by one: SEG follows value[3:0] two edges later.
    @(negedge CLK);
    rst_b = 1'b1;
    vb    = 32'd0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    rst_b = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    prev = 8'hC0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      vb = tbl[i].v;
      @(posedge CLK);
      @(negedge CLK);
      check("div1_hold_SEG", i, ifb.SEG, prev);
      @(posedge CLK);
      @(negedge CLK);
      check("div1_SEG", i, ifb.SEG, tbl[i].seg);
      check("div1_AN", i, ifb.AN, 8'hFE);
      prev = tbl[i].seg;
    end

    // Randomized words on an active-high 5-digit build and the 8-digit build.
    run_model(2, 3, 5, 0, 400, $urandom, 1'b1, 0, 32'd0);
    run_model(0, 4, 8, 1, 600, $urandom, 1'b1, 0, 32'd0);

    // Short and zero words, where leading-zero handling matters.
    run_model(0, 4, 8, 1, 70, 32'h0000_001F, 1'b0, 0, 32'd0);
    run_model(0, 4, 8, 1, 40, 32'h0000_0000, 1'b0, 0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
